// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - Fetch-unit bus bundle: hazard/redirect inputs, PC-adder loop, imem handshake
//
// Signals:
//   stall, redirect_valid, redirect_target   control from hazard unit / branch resolution
//   pc_next_seq                              PC-incrementer adder Y result (pc + STEP)
//   imem_ready, imem_req                     instruction memory handshake
//   pc                                       current PC (adder A input and imem address)
//   fetch_valid, fetch_pc                    registered accepted-fetch report
//   misaligned                               sticky misaligned-redirect flag
// Modports: master = fetch unit, slave = surrounding front end.
interface pc_fetch_unit_if #(
    parameter int unsigned N = 32
);
    logic         stall;
    logic         redirect_valid;
    logic [N-1:0] redirect_target;
    logic [N-1:0] pc_next_seq;
    logic         imem_ready;
    logic [N-1:0] pc;
    logic         imem_req;
    logic         fetch_valid;
    logic [N-1:0] fetch_pc;
    logic         misaligned;

    modport master (
        input  stall, redirect_valid, redirect_target, pc_next_seq, imem_ready,
        output pc, imem_req, fetch_valid, fetch_pc, misaligned
    );

    modport slave (
        output stall, redirect_valid, redirect_target, pc_next_seq, imem_ready,
        input  pc, imem_req, fetch_valid, fetch_pc, misaligned
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - Program counter register and fetch sequencer (BOOT/FETCH/HOLD/TRAP)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   bus           pc_fetch_unit_if.master (stall, redirect, adder loop, imem handshake, fetch report)
//   fetch_count   accepted-fetch counter      (only with FETCH_PERF_EN)
//   stall_cycles  cycles spent in HOLD        (only with FETCH_PERF_EN)
// Optional feature macro: FETCH_PERF_EN adds the two 32-bit performance counters.
module pc_fetch_unit #(
    parameter int unsigned     N            = 32,
    parameter logic [N-1:0]    RESET_VECTOR = '0,
    parameter int unsigned     STEP         = 4
) (
    input  logic              clk,
    input  logic              reset,
    pc_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_cycles
`endif
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    // Only the low log2(STEP) bits decide alignment; STEP is a power of two.
    localparam logic [N-1:0] ALIGN_MASK = N'(STEP - 1);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] pc_q;
    logic [N-1:0] fetch_pc_q;
    logic         fetch_valid_q;
    logic         misaligned_q;

    logic redirect_take;
    logic target_misaligned;
    logic accept;

    // TRAP ignores redirect and stall entirely.
    assign redirect_take     = bus.redirect_valid && (state != TRAP);
    assign target_misaligned = (bus.redirect_target & ALIGN_MASK) != '0;
    assign accept            = (state == FETCH) && !bus.redirect_valid && !bus.stall && bus.imem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: redirect > stall > sequential
    always_comb begin
        state_next = state;
        if (state == TRAP) begin
            state_next = TRAP;
        end else if (bus.redirect_valid) begin
            state_next = target_misaligned ? TRAP : FETCH;
        end else if (bus.stall) begin
            state_next = HOLD;
        end else begin
            state_next = FETCH;
        end
    end

    // Output decode
    always_comb begin
        bus.imem_req = 1'b0;
        if (state == FETCH) begin
            bus.imem_req = 1'b1;
        end
    end

    // PC and fetch-report datapath. A redirect in the acceptance cycle wins,
    // so the in-flight fetch is squashed (accept already excludes it).
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            fetch_valid_q <= accept;
            if (accept) begin
                fetch_pc_q <= pc_q;
                pc_q       <= bus.pc_next_seq;
            end
            if (redirect_take) begin
                pc_q <= bus.redirect_target;
                if (target_misaligned) begin
                    misaligned_q <= 1'b1;
                end
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_pc    = fetch_pc_q;
    assign bus.misaligned  = misaligned_q;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (state == HOLD) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - Self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
    localparam int unsigned N    = 32;
    localparam int unsigned STEP = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [N-1:0] exp_q[$];

    pc_fetch_unit_if #(.N(N)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    pc_fetch_unit #(
        .N(N),
        .RESET_VECTOR(32'h0000_0000),
        .STEP(STEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count),
        .stall_cycles(stall_cycles)
`endif
    );

    // Behavioural PC incrementer (the upstream adder).
    assign bus.pc_next_seq = bus.pc + N'(STEP);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every fetch report must match the next pushed expectation.
    always @(negedge clk) begin
        if (!reset && bus.fetch_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL fetch_unexpected actual_fetch_pc=%h required=no_fetch", bus.fetch_pc);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (bus.fetch_pc !== e) begin
                    failures++;
                    $display("FAIL fetch_pc actual=%h expected=%h", bus.fetch_pc, e);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus.imem_ready = 1'b0;
        step();
        step();
        checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", bus.pc, 32'h0); end
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req actual=%b expected=0", bus.imem_req); end
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid actual=%b expected=0", bus.fetch_valid); end
        checks++; if (bus.fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_fetch_pc actual=%h expected=0", bus.fetch_pc); end
        checks++; if (bus.misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned actual=%b expected=0", bus.misaligned); end
    endtask

    // Reset released with imem_ready held: pc 0 (BOOT), 0, 4, 8.
    task automatic test_sequential();
        logic [N-1:0] exp_pc[3];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL boot_imem_req actual=%b expected=0", bus.imem_req); end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.pc !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d] actual=%h expected=%h", i, bus.pc, exp_pc[i]); end
            checks++;
            if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL seq_imem_req[%0d] actual=%b expected=1", i, bus.imem_req); end
            if (i < 2) begin
                exp_q.push_back(exp_pc[i]);
                step();
            end
        end
    endtask

    // At pc=8 in FETCH: 3 stall cycles, then resume with fetch of 8.
    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_imem_req[%0d] actual=%b expected=0", i, bus.imem_req); end
            checks++; if (bus.pc !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d] actual=%h expected=8", i, bus.pc); end
            checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL stall_fetch_valid[%0d] actual=%b expected=0", i, bus.fetch_valid); end
        end
        bus.stall = 1'b0;
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.pc !== 32'h8) begin failures++; $display("FAIL stall_release actual_req=%b actual_pc=%h expected_req=1 expected_pc=8", bus.imem_req, bus.pc); end
        exp_q.push_back(32'h8);
        step();
        exp_q.push_back(32'hC);
        step();
        checks++; if (bus.pc !== 32'h10) begin failures++; $display("FAIL stall_after_pc actual=%h expected=10", bus.pc); end
    endtask

    // Acceptance at pc=10 squashed by a same-cycle redirect to 40.
    task automatic test_redirect_squash();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0040;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL squash_fetch_valid actual=%b expected=0", bus.fetch_valid); end
        checks++; if (bus.pc !== 32'h40) begin failures++; $display("FAIL squash_pc actual=%h expected=40", bus.pc); end
        exp_q.push_back(32'h40);
        step();
        checks++; if (bus.pc !== 32'h44) begin failures++; $display("FAIL post_redirect_pc actual=%h expected=44", bus.pc); end
    endtask

    // Misaligned redirect traps; later redirects/stalls are ignored; reset clears.
    task automatic test_misaligned_trap();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0042;
        step();
        bus.redirect_target = 32'h0000_0080;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.misaligned !== 1'b1) begin failures++; $display("FAIL trap_misaligned[%0d] actual=%b expected=1", i, bus.misaligned); end
            checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL trap_imem_req[%0d] actual=%b expected=0", i, bus.imem_req); end
            checks++; if (bus.pc !== 32'h42) begin failures++; $display("FAIL trap_pc[%0d] actual=%h expected=42", i, bus.pc); end
            bus.stall = (i == 1);
            step();
        end
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL trap_reset_pc actual=%h expected=0", bus.pc); end
        checks++; if (bus.misaligned !== 1'b0) begin failures++; $display("FAIL trap_reset_misaligned actual=%b expected=0", bus.misaligned); end
    endtask

    // Redirect accepted during BOOT to FFFF_FFFC, then one acceptance wraps to 0.
    task automatic test_wrap();
        bus.imem_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_boot_redirect_pc actual=%h expected=fffffffc", bus.pc); end
        exp_q.push_back(32'hFFFF_FFFC);
        step();
        bus.imem_ready = 1'b0;
        checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL wrap_pc actual=%h expected=0", bus.pc); end
        checks++; if (bus.misaligned !== 1'b0) begin failures++; $display("FAIL wrap_misaligned actual=%b expected=0", bus.misaligned); end
        step();
        // imem_ready low: request held, pc frozen, no fetch report.
        checks++; if (bus.pc !== 32'h0 || bus.imem_req !== 1'b1 || bus.fetch_valid !== 1'b0) begin
            failures++; $display("FAIL not_ready actual_pc=%h req=%b fv=%b expected_pc=0 req=1 fv=0", bus.pc, bus.imem_req, bus.fetch_valid);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin exp_q.push_back(bus.pc); step(); end
        bus.stall = 1'b1;
        step();
        step();
        bus.stall = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin exp_q.push_back(32'(12 + 4 * i)); step(); end
        bus.imem_ready = 1'b0;
        step();
        checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL perf_fetch_count actual=%0d expected=5", fetch_count); end
        checks++; if (stall_cycles !== 32'd2) begin failures++; $display("FAIL perf_stall_cycles actual=%0d expected=2", stall_cycles); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (fetch_count !== 32'd0 || stall_cycles !== 32'd0) begin failures++; $display("FAIL perf_reset actual=%0d/%0d expected=0/0", fetch_count, stall_cycles); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_squash();
        test_misaligned_trap();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual_pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
